booth_mul_r4: RTL and testbench

- Sequential signed radix-4 Booth multiplier core.
- Sits directly downstream of the ALU-with-multiplier bus-slave register block.
- The slave hands it latched operandA/operandB plus start/clear controls when opcode selects multiply, and reads back a 64-bit product and a done status.
- Processes 2 multiplier bits per cycle. Operands are held internally, so the slave's registers may change once a multiply is accepted.

---
 rtl/booth_mul_r4.sv | 113 +++++++++++
 tb/tb_booth_mul_r4.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/booth_mul_r4.sv
// Sequential signed radix-4 Booth multiplier, two multiplier bits per cycle; result valid WIDTH/2 edges after start.
// No backpressure: DONE holds the product until op_clear, and op_start is ignored outside IDLE.
module booth_mul_r4 #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 op_start,
  input  logic                 op_clear,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   result,
  output logic [1:0]           op_done
);

  localparam int ITER = WIDTH / 2;
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b11
  } state_t;

  state_t            state, state_nxt;
  logic [WIDTH+1:0]  m;
  logic [WIDTH+1:0]  a;
  logic [WIDTH-1:0]  q;
  logic              q_m1;
  logic [CW-1:0]     cnt;

  logic [WIDTH+1:0]  addend;
  logic [WIDTH+1:0]  a_sum;
  logic [WIDTH+1:0]  a_nxt;
  logic [WIDTH-1:0]  q_nxt;

  // M and A carry two guard bits so that +/-2M of the most-negative operand never wraps.
  always_comb begin
    addend = '0;
    case ({q[1], q[0], q_m1})
      3'b001, 3'b010: addend = m;
      3'b011:         addend = {m[WIDTH:0], 1'b0};
      3'b100:         addend = -{m[WIDTH:0], 1'b0};
      3'b101, 3'b110: addend = -m;
      default:        addend = '0;
    endcase
    a_sum = a + addend;
    a_nxt = {{2{a_sum[WIDTH+1]}}, a_sum[WIDTH+1:2]};
    q_nxt = {a_sum[1:0], q[WIDTH-1:2]};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (op_clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (op_start) state_nxt = EXEC;
        EXEC:    if (cnt == LAST) state_nxt = DONE;
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    op_done = state;
  end

  always_ff @(posedge clk) begin
    if (!reset_n || op_clear) begin
      m      <= '0;
      a      <= '0;
      q      <= '0;
      q_m1   <= 1'b0;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (op_start) begin
            m    <= {{2{multiplicand[WIDTH-1]}}, multiplicand};
            q    <= multiplier;
            q_m1 <= 1'b0;
            a    <= '0;
            cnt  <= '0;
          end
        end
        EXEC: begin
          a    <= a_nxt;
          q    <= q_nxt;
          q_m1 <= q[1];
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            result <= {a_nxt[WIDTH-1:0], q_nxt};
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_r4.sv
// Directed and randomized checks of booth_mul_r4 against a plain-arithmetic signed product model.
module tb_booth_mul_r4;
  localparam int W    = 32;
  localparam int ITER = W / 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            op_start;
  logic            op_clear;
  logic [W-1:0]    multiplicand;
  logic [W-1:0]    multiplier;
  logic [2*W-1:0]  result;
  logic [1:0]      op_done;

  int tests = 0;
  int fails = 0;

  booth_mul_r4 #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .op_start     (op_start),
    .op_clear     (op_clear),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .result       (result),
    .op_done      (op_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    longint sx;
    longint sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    return 64'(sx * sy);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a multiply, scrambles operand inputs while busy, optionally pulses op_start at edge t0+restart_at.
  task automatic run_mul(input string tag, input logic [31:0] x, input logic [31:0] y, input int restart_at);
    logic [63:0] exp;
    exp = ref_mul(x, y);
    multiplicand = x;
    multiplier   = y;
    op_start     = 1'b1;
    tick();
    for (int k = 0; k < ITER; k++) begin
      check({tag, " busy"}, {62'b0, op_done}, 64'd1);
      check({tag, " result0"}, result, 64'd0);
      multiplicand = $urandom;
      multiplier   = $urandom;
      op_start     = (k == restart_at - 1);
      tick();
    end
    op_start = 1'b0;
    check({tag, " done"}, {62'b0, op_done}, 64'd3);
    check({tag, " product"}, result, exp);
  endtask

  task automatic clear_op(input string tag);
    op_clear = 1'b1;
    tick();
    op_clear = 1'b0;
    check({tag, " clr done"}, {62'b0, op_done}, 64'd0);
    check({tag, " clr result"}, result, 64'd0);
  endtask

  initial begin
    reset_n      = 1'b0;
    op_start     = 1'b0;
    op_clear     = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    tick();
    tick();
    check("reset done", {62'b0, op_done}, 64'd0);
    check("reset result", result, 64'd0);
    reset_n = 1'b1;
    tick();
    check("idle done", {62'b0, op_done}, 64'd0);

    run_mul("3x5", 32'd3, 32'd5, -1);
    check("3x5 literal", result, 64'h0000_0000_0000_000F);
    clear_op("3x5");

    run_mul("-7x6", 32'hFFFF_FFF9, 32'd6, -1);
    check("-7x6 literal", result, 64'hFFFF_FFFF_FFFF_FFD6);
    clear_op("-7x6");

    run_mul("min x min", 32'h8000_0000, 32'h8000_0000, -1);
    check("min x min literal", result, 64'h4000_0000_0000_0000);
    clear_op("min x min");

    run_mul("max x min", 32'h7FFF_FFFF, 32'h8000_0000, -1);
    check("max x min literal", result, 64'hC000_0000_8000_0000);
    clear_op("max x min");

    run_mul("0 x -1", 32'd0, 32'hFFFF_FFFF, -1);
    clear_op("0 x -1");

    run_mul("restart ignored", 32'd12345, 32'hFFFF_FC18, 5);
    check("restart literal", result, 64'hFFFF_FFFF_FF43_A158);
    clear_op("restart");

    // abort with op_clear at edge t0+8
    multiplicand = 32'd77;
    multiplier   = 32'd99;
    op_start     = 1'b1;
    tick();
    op_start = 1'b0;
    repeat (7) tick();
    op_clear = 1'b1;
    tick();
    op_clear = 1'b0;
    check("abort done", {62'b0, op_done}, 64'd0);
    check("abort result", result, 64'd0);
    tick();
    check("abort stays idle", {62'b0, op_done}, 64'd0);

    // reset at edge t0+4 of a second run
    op_start = 1'b1;
    tick();
    op_start = 1'b0;
    repeat (3) tick();
    reset_n = 1'b0;
    tick();
    check("midreset done", {62'b0, op_done}, 64'd0);
    check("midreset result", result, 64'd0);
    reset_n = 1'b1;
    tick();
    check("post reset idle", {62'b0, op_done}, 64'd0);

    run_mul("2x-3", 32'd2, 32'hFFFF_FFFD, -1);
    check("2x-3 literal", result, 64'hFFFF_FFFF_FFFF_FFFA);

    op_start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold done", {62'b0, op_done}, 64'd3);
      check("hold result", result, 64'hFFFF_FFFF_FFFF_FFFA);
    end
    op_start = 1'b0;
    clear_op("hold");

    op_start = 1'b1;
    op_clear = 1'b1;
    tick();
    check("clear beats start", {62'b0, op_done}, 64'd0);
    op_start = 1'b0;
    op_clear = 1'b0;
    tick();
    check("start dropped", {62'b0, op_done}, 64'd0);

    for (int r = 0; r < 25; r++) begin
      run_mul("random", $urandom, $urandom, int'($urandom_range(1, ITER - 1)));
      clear_op("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
